// File: rtl/regfile.sv
// Register file: 2^ADDR_WIDTH x DATA_WIDTH, two combinational read ports,
// one write port, register 0 hardwired to zero. After reset an internal
// clear sequence zeroes registers 1..N-1, one per cycle, with busy high.
//
// Ports:
//   clk                  rising-edge clock for all state
//   reset_n              synchronous active-low reset
//   rd_addr1 / rd_addr2  read indices (rs / rt)
//   rd_data1 / rd_data2  combinational read data (ALU operands)
//   wr_en/wr_addr/wr_data  write request (ignored while clearing)
//   busy                 registered, high while the clear sequence runs
module regfile #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  input  logic [ADDR_WIDTH-1:0] rd_addr2,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic [DATA_WIDTH-1:0] rd_data2,
  output logic                  busy
);

  localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   mem_q [NUM_REGS];

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  // Next-state and write-port selection: clear sweep or user write.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mem_we    = 1'b0;
    mem_waddr = idx_q;
    mem_wdata = '0;

    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = idx_q;
      // Last index is cleared on the same edge that leaves CLEAR, so idx never wraps.
      if (idx_q == '1) begin
        state_d = RUN;
      end else begin
        idx_d = idx_q + ADDR_WIDTH'(1);
      end
    end else begin
      if (wr_en && (wr_addr != '0)) begin
        mem_we    = 1'b1;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
      end
    end

    // Reset has priority: no register changes, any same-cycle write is dropped.
    if (!reset_n) begin
      state_d = CLEAR;
      idx_d   = ADDR_WIDTH'(1);
      mem_we  = 1'b0;
    end

    busy_d = (state_d == CLEAR);
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      idx_q   <= ADDR_WIDTH'(1);
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  // Storage array; entry 0 is never written and never read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read port 1: zero reg / clearing -> 0, else write-through bypass, else storage.
  always_comb begin
    rd_data1 = '0;
    if ((state_q == RUN) && (rd_addr1 != '0)) begin
      if (wr_en && (wr_addr == rd_addr1)) begin
        rd_data1 = wr_data;
      end else begin
        rd_data1 = mem_q[rd_addr1];
      end
    end
  end

  // Read port 2: identical structure to port 1.
  always_comb begin
    rd_data2 = '0;
    if ((state_q == RUN) && (rd_addr2 != '0)) begin
      if (wr_en && (wr_addr == rd_addr2)) begin
        rd_data2 = wr_data;
      end else begin
        rd_data2 = mem_q[rd_addr2];
      end
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: expected read values are queued as reads are
// driven and popped when the outputs are sampled.
module tb_regfile;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] rd_addr1, rd_addr2, wr_addr;
  logic          wr_en;
  logic [DW-1:0] wr_data, rd_data1, rd_data2;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string         tag;
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive both read addresses and queue the values they must return.
  task automatic set_rd(input string tag, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    exp_t e;
    rd_addr1 = a1;
    rd_addr2 = a2;
    e.tag  = tag;
    e.exp1 = e1;
    e.exp2 = e2;
    sb_q.push_back(e);
  endtask

  // Sample the read ports mid-cycle and compare against the queued entry.
  task automatic check_rd();
    exp_t e;
    #1;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_underflow observed=empty expected=entry");
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_rd1"}, rd_data1, e.exp1);
      chk({e.tag, "_rd2"}, rd_data2, e.exp2);
    end
  endtask

  // Run n clear cycles checking busy and zero reads; optionally attempt a write at cycle wcyc.
  task automatic run_clear(input int n, input int wcyc);
    for (int i = 0; i < n; i++) begin
      wr_en   = (i == wcyc);
      wr_addr = AW'(3);
      wr_data = 32'hA5A5_A5A5;
      set_rd($sformatf("clear_c%0d", i), AW'($urandom_range(31, 1)), AW'(3), '0, '0);
      check_rd();
      chk($sformatf("clear_busy_c%0d", i), DW'(busy), DW'(1));
      tick();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr1 = '0;
    rd_addr2 = '0;

    // Reset held for two edges.
    tick();
    tick();
    chk("reset_busy", DW'(busy), DW'(1));
    set_rd("reset", AW'(4), AW'(17), '0, '0);
    check_rd();

    // Full clear: busy for exactly 31 edges; write at cycle 10 is dropped.
    reset_n = 1'b1;
    run_clear(31, 10);
    chk("busy_fall", DW'(busy), DW'(0));

    // Every register reads zero after the clear, including reg3.
    for (int a = 0; a < 32; a++) begin
      set_rd($sformatf("zero_r%0d", a), AW'(a), AW'(31 - a), '0, '0);
      check_rd();
    end

    // Plain write then read on both ports.
    wr_en = 1'b1; wr_addr = AW'(5); wr_data = 32'hDEAD_BEEF;
    tick();
    wr_en = 1'b0;
    set_rd("reg5", AW'(5), AW'(5), 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    check_rd();

    // Same-cycle write-through bypass on both ports, then stored value.
    wr_en = 1'b1; wr_addr = AW'(7); wr_data = 32'h1234_5678;
    set_rd("byp7", AW'(7), AW'(7), 32'h1234_5678, 32'h1234_5678);
    check_rd();
    tick();
    wr_en = 1'b0;
    set_rd("reg7", AW'(5), AW'(7), 32'hDEAD_BEEF, 32'h1234_5678);
    check_rd();

    // Bypass on one port only; other port reads storage.
    wr_en = 1'b1; wr_addr = AW'(12); wr_data = 32'h0F0F_1234;
    set_rd("byp12", AW'(12), AW'(7), 32'h0F0F_1234, 32'h1234_5678);
    check_rd();
    tick();
    wr_en = 1'b0;
    set_rd("reg12", AW'(7), AW'(12), 32'h1234_5678, 32'h0F0F_1234);
    check_rd();

    // Writes to register 0 are discarded and never bypassed.
    wr_en = 1'b1; wr_addr = AW'(0); wr_data = 32'hFFFF_FFFF;
    set_rd("wr0_same", AW'(0), AW'(5), '0, 32'hDEAD_BEEF);
    check_rd();
    tick();
    wr_en = 1'b0;
    set_rd("wr0_after", AW'(0), AW'(0), '0, '0);
    check_rd();

    // reg9 = 0x55 in RUN.
    wr_en = 1'b1; wr_addr = AW'(9); wr_data = 32'h0000_0055;
    tick();
    wr_en = 1'b0;
    set_rd("reg9", AW'(9), AW'(12), 32'h0000_0055, 32'h0F0F_1234);
    check_rd();

    // Reset in RUN with a same-cycle write, then restart mid-clear at cycle 15.
    reset_n = 1'b0;
    wr_en = 1'b1; wr_addr = AW'(9); wr_data = 32'h0000_0077;
    tick();
    wr_en = 1'b0;
    chk("rst_run_busy", DW'(busy), DW'(1));
    reset_n = 1'b1;
    run_clear(15, -1);
    reset_n = 1'b0;
    tick();
    chk("rst_mid_busy", DW'(busy), DW'(1));
    reset_n = 1'b1;
    run_clear(31, -1);
    chk("busy_fall2", DW'(busy), DW'(0));
    set_rd("post_rst_9_5", AW'(9), AW'(5), '0, '0);
    check_rd();
    set_rd("post_rst_7_12", AW'(7), AW'(12), '0, '0);
    check_rd();

    chk("sb_empty", DW'(sb_q.size()), DW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, the register width.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 5, the register index width (2^ADDR_WIDTH entries).
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port reset_n, input, 1 bit, a synchronous active-low reset sampled on the rising clk edge.
REQ-005 The module SHALL have port rd_addr1, input, ADDR_WIDTH, the read port 1 index (rs).
REQ-006 The module SHALL have port rd_addr2, input, ADDR_WIDTH, the read port 2 index (rt).
REQ-007 The module SHALL have port wr_en, input, 1 bit, the write request.
REQ-008 The module SHALL have port wr_addr, input, ADDR_WIDTH, the write index (rd/rt).
REQ-009 The module SHALL have port wr_data, input, DATA_WIDTH, the write value (ALU result or load data).
REQ-010 The module SHALL have port rd_data1, output, DATA_WIDTH, the read port 1 value, which drives the ALU first operand.
REQ-011 The module SHALL have port rd_data2, output, DATA_WIDTH, the read port 2 value, which drives the ALU second operand.
REQ-012 The module SHALL have port busy, output, 1 bit, a registered flag that is high while the clear sequence runs.

Function
REQ-013 The module SHALL hold 2^ADDR_WIDTH registers; register 0 SHALL read as zero at all times and SHALL never be written.
REQ-014 The module SHALL implement a two-state FSM, CLEAR and RUN, with busy = (state == CLEAR).
REQ-015 In CLEAR, the module SHALL write zero to one register per cycle, using a clear index idx that starts at 1 and increments by 1 each cycle.
REQ-016 In CLEAR, when idx reaches 2^ADDR_WIDTH-1, the module SHALL clear that register on that edge and transition to RUN on the same edge.
REQ-017 With defaults, busy SHALL be high for exactly 31 cycles after the first clk edge that samples reset_n = 1.
REQ-018 In RUN, at a clk edge where wr_en = 1 and wr_addr != 0, the module SHALL store wr_data into register wr_addr.
REQ-019 In RUN, a write with wr_addr = 0 SHALL be silently discarded.
REQ-020 In CLEAR, wr_en SHALL be ignored; the write is dropped, not queued.
REQ-021 Reads SHALL be combinational with zero latency: rd_dataN = 0 if rd_addrN = 0; else wr_data if state = RUN, wr_en = 1 and wr_addr = rd_addrN (write-through bypass); else the stored register value.
REQ-022 In CLEAR, rd_data1 and rd_data2 SHALL both read 0 regardless of address.
REQ-023 Both read ports SHALL operate independently; equal addresses on the two ports SHALL return identical values, including the bypass case.
REQ-024 The module SHALL perform no arithmetic on data; idx SHALL be ADDR_WIDTH bits wide and SHALL never wrap while in CLEAR.

Reset
REQ-025 When reset_n = 0 at a rising clk edge, the module SHALL set state to CLEAR, idx to 1, and busy to 1.
REQ-026 While reset_n is held low, the module SHALL remain in CLEAR with idx = 1, and no register SHALL change.
REQ-027 Reset asserted mid-CLEAR SHALL restart the sequence at idx = 1; reset asserted in RUN SHALL discard any same-cycle write and clear all contents through the full sequence.
REQ-028 State before the first reset SHALL be undefined; the system SHALL apply reset before use.

Verification
REQ-029 The bench SHALL cover: reset_n low for 2 edges, then high -> busy = 1 for exactly 31 edges then 0; rd_data1 = rd_data2 = 0 throughout CLEAR; all registers read 0 afterward.
REQ-030 The bench SHALL cover: in RUN, write reg5 = 0xDEADBEEF, then read rd_addr1 = 5 and rd_addr2 = 5 -> both 0xDEADBEEF on the next cycle.
REQ-031 The bench SHALL cover: in RUN, in the same cycle, wr_en = 1, wr_addr = 7, wr_data = 0x12345678, rd_addr2 = 7 -> rd_data2 = 0x12345678 combinationally, and reg7 holds the value after the edge.
REQ-032 The bench SHALL cover: write reg0 = 0xFFFFFFFF with rd_addr1 = 0 in the same cycle and afterward -> rd_data1 = 0 both times.
REQ-033 The bench SHALL cover: wr_en = 1, wr_addr = 3, wr_data = 0xA5A5A5A5 during CLEAR cycle 10 -> reg3 reads 0 after busy falls.
REQ-034 The bench SHALL cover: reg9 = 0x55 in RUN, then reset_n pulsed low at CLEAR cycle 15 -> busy stays high 31 more cycles after release; reg9 reads 0.
